fetch_unit: RTL and testbench

- Program-counter / fetch stage of the 9-bit core. It drives the instruction-ROM address and consumes the control decoder's branch outputs: ConditionalJump, BranchAbsOrRel, BranchConditions, the 2-bit PCTarg index and Ack.
- Resolves branches against registered compare flags through a small writable branch-target LUT.
- Sequences the program: load, run, halt. Raises Done when the decoder reports Ack.

---
 rtl/fetch_unit.sv | 144 ++++++++++++++
 tb/tb_fetch_unit.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Program-counter / fetch stage: LOAD/RUN/HALT sequencing with a writable branch-target LUT.
// Define FETCH_PERF_CNT_EN to build the saturating cycle and taken-branch counters.
module fetch_unit #(
    parameter int PC_W   = 10,
    parameter int LUT_AW = 2
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              Start,
    input  logic              ConditionalJump,
    input  logic              BranchAbsOrRel,
    input  logic [1:0]        BranchConditions,
    input  logic [LUT_AW-1:0] PCTarg,
    input  logic              Ack,
    input  logic              FlagEq,
    input  logic              FlagLt,
    input  logic              LutWrEn,
    input  logic [LUT_AW-1:0] LutWrAddr,
    input  logic [PC_W-1:0]   LutWrData,
    output logic [PC_W-1:0]   ProgCtr,
    output logic              Running,
    output logic              Done,
    output logic [15:0]       CycleCount,
    output logic [15:0]       TakenCount
);
    localparam int LUT_D = 2**LUT_AW;
    localparam logic [PC_W-1:0] PC_ONE = 1;

    typedef enum logic [1:0] {S_LOAD, S_RUN, S_HALT} state_t;

    state_t          r_state;
    logic [PC_W-1:0] r_pc;
    logic            r_running;
    logic            r_done;
    logic [PC_W-1:0] r_lut [LUT_D];

    logic            w_cond_ok;
    logic            w_taken;
    logic [PC_W-1:0] w_lut_val;
    logic [PC_W-1:0] w_target;

    always_comb begin
        w_cond_ok = 1'b0;
        case (BranchConditions)
            2'b00:   w_cond_ok = 1'b1;
            2'b01:   w_cond_ok = FlagEq;
            2'b10:   w_cond_ok = FlagLt;
            default: w_cond_ok = !FlagEq;
        endcase
    end

    // Relative targets use the LUT entry as a two's-complement offset; modulo wrap is free.
    assign w_lut_val = r_lut[PCTarg];
    assign w_target  = BranchAbsOrRel ? (r_pc + w_lut_val) : w_lut_val;
    assign w_taken   = (r_state == S_RUN) && !Start && !Ack && ConditionalJump && w_cond_ok;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < LUT_D; i++) r_lut[i] <= '0;
        end else if (LutWrEn) begin
            r_lut[LutWrAddr] <= LutWrData;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state   <= S_LOAD;
            r_pc      <= '0;
            r_running <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    r_pc <= '0;
                    if (!Start) begin
                        r_state   <= S_RUN;
                        r_running <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (Start) begin
                        r_state   <= S_LOAD;
                        r_pc      <= '0;
                        r_running <= 1'b0;
                    end else if (Ack) begin
                        r_state   <= S_HALT;
                        r_running <= 1'b0;
                        r_done    <= 1'b1;
                    end else if (w_taken) begin
                        r_pc <= w_target;
                    end else begin
                        r_pc <= r_pc + PC_ONE;
                    end
                end
                S_HALT: begin
                    if (Start) begin
                        r_state <= S_LOAD;
                        r_pc    <= '0;
                        r_done  <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= S_LOAD;
                    r_pc      <= '0;
                    r_running <= 1'b0;
                    r_done    <= 1'b0;
                end
            endcase
        end
    end

    assign ProgCtr = r_pc;
    assign Running = r_running;
    assign Done    = r_done;

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] r_cycle_cnt;
    logic [15:0] r_taken_cnt;
    logic        w_run_start;

    assign w_run_start = (r_state == S_LOAD) && !Start;

    // Counters restart with each program launch and freeze outside RUN.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_cycle_cnt <= '0;
            r_taken_cnt <= '0;
        end else if (w_run_start) begin
            r_cycle_cnt <= '0;
            r_taken_cnt <= '0;
        end else if (r_state == S_RUN) begin
            if (r_cycle_cnt != 16'hFFFF) r_cycle_cnt <= r_cycle_cnt + 16'd1;
            if (w_taken && (r_taken_cnt != 16'hFFFF)) r_taken_cnt <= r_taken_cnt + 16'd1;
        end
    end

    assign CycleCount = r_cycle_cnt;
    assign TakenCount = r_taken_cnt;
`else
    assign CycleCount = '0;
    assign TakenCount = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: driver pushes model predictions, monitor pops and compares.
module tb_fetch_unit;
    logic       Clk = 1'b0;
    logic       Reset_n;
    logic       Start;
    logic       ConditionalJump;
    logic       BranchAbsOrRel;
    logic [1:0] BranchConditions;
    logic [1:0] PCTarg;
    logic       Ack;
    logic       FlagEq;
    logic       FlagLt;
    logic       LutWrEn;
    logic [1:0] LutWrAddr;
    logic [9:0] LutWrData;
    logic [9:0] ProgCtr;
    logic       Running;
    logic       Done;
    logic [15:0] CycleCount;
    logic [15:0] TakenCount;

    fetch_unit #(.PC_W(10), .LUT_AW(2)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start),
        .ConditionalJump(ConditionalJump), .BranchAbsOrRel(BranchAbsOrRel),
        .BranchConditions(BranchConditions), .PCTarg(PCTarg), .Ack(Ack),
        .FlagEq(FlagEq), .FlagLt(FlagLt), .LutWrEn(LutWrEn),
        .LutWrAddr(LutWrAddr), .LutWrData(LutWrData), .ProgCtr(ProgCtr),
        .Running(Running), .Done(Done), .CycleCount(CycleCount), .TakenCount(TakenCount)
    );

    always #5 Clk = ~Clk;

`ifdef FETCH_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    typedef struct {
        int pc;
        bit run;
        bit done;
        int cc;
        int tc;
    } exp_t;

    exp_t q[$];
    int n_checks = 0;
    int n_errors = 0;

    // Reference model: program phase as two flags, PC and LUT as plain integers.
    int m_pc = 0;
    bit m_run = 0;
    bit m_done = 0;
    int m_cc = 0;
    int m_tc = 0;
    int m_lut[4] = '{0, 0, 0, 0};

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 0; m_run = 0; m_done = 0; m_cc = 0; m_tc = 0;
        for (int i = 0; i < 4; i++) m_lut[i] = 0;
    endtask

    function automatic int sat16(input int v);
        return (v > 65535) ? 65535 : v;
    endfunction

    // Called on a falling edge: drive one cycle of inputs, predict, wait for next falling edge.
    task automatic step(input bit st, input bit cj, input bit ar, input int bc, input int tg,
                        input bit ak, input bit fe, input bit fl,
                        input bit we, input int wa, input int wd);
        exp_t e;
        int tgt;
        bit ok;
        Start = st; ConditionalJump = cj; BranchAbsOrRel = ar;
        BranchConditions = 2'(bc); PCTarg = 2'(tg); Ack = ak;
        FlagEq = fe; FlagLt = fl; LutWrEn = we; LutWrAddr = 2'(wa); LutWrData = 10'(wd);
        if (!Reset_n) begin
            model_reset();
        end else begin
            tgt = ar ? (m_pc + m_lut[tg]) % 1024 : m_lut[tg];
            ok = (bc == 0) ? 1'b1 : (bc == 1) ? fe : (bc == 2) ? fl : !fe;
            if (m_run) begin
                m_cc = sat16(m_cc + 1);
                if (st) begin
                    m_run = 0; m_pc = 0;
                end else if (ak) begin
                    m_run = 0; m_done = 1;
                end else if (cj && ok) begin
                    m_pc = tgt; m_tc = sat16(m_tc + 1);
                end else begin
                    m_pc = (m_pc + 1) % 1024;
                end
            end else if (m_done) begin
                if (st) begin
                    m_done = 0; m_pc = 0;
                end
            end else begin
                m_pc = 0;
                if (!st) begin
                    m_run = 1; m_cc = 0; m_tc = 0;
                end
            end
            if (we) m_lut[wa] = wd;
        end
        e.pc = m_pc; e.run = m_run; e.done = m_done;
        e.cc = PERF ? m_cc : 0;
        e.tc = PERF ? m_tc : 0;
        q.push_back(e);
        @(negedge Clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic lutw(input int a, input int d);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, a, d);
    endtask

    task automatic brn(input bit ar, input int bc, input int tg, input bit fe, input bit fl);
        step(0, 1, ar, bc, tg, 0, fe, fl, 0, 0, 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_pc"}, ProgCtr, 0);
        chk({tag, "_running"}, Running, 0);
        chk({tag, "_done"}, Done, 0);
        chk({tag, "_cycles"}, CycleCount, 0);
        chk({tag, "_taken"}, TakenCount, 0);
    endtask

    task automatic run_to(input int pc);
        for (int i = 0; i < 1100 && m_pc != pc; i++) idle(1);
    endtask

    // Monitor: outputs are presented every cycle; compare shortly after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge Clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("pc", ProgCtr, e.pc);
                chk("running", Running, e.run);
                chk("done", Done, e.done);
                chk("cycles", CycleCount, e.cc);
                chk("taken", TakenCount, e.tc);
            end
        end
    end

    initial begin
        Reset_n = 1'b0; Start = 1'b1; ConditionalJump = 0; BranchAbsOrRel = 0;
        BranchConditions = 0; PCTarg = 0; Ack = 0; FlagEq = 0; FlagLt = 0;
        LutWrEn = 0; LutWrAddr = 0; LutWrData = 0;
        repeat (2) @(negedge Clk);
        chk_reset_outputs("reset");
        Reset_n = 1'b1;

        // Load, then run straight-line code
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(5);

        // Absolute unconditional branch
        lutw(2, 'h040);
        run_to(5);
        brn(0, 0, 2, 0, 0);
        idle(1);

        // Relative branch with negative offset, taken and not taken
        lutw(1, 'h3FE);
        lutw(0, 'h010);
        brn(0, 0, 0, 0, 0);
        brn(1, 1, 1, 1, 0);
        run_to('h010);
        brn(1, 1, 1, 0, 0);
        brn(1, 2, 1, 0, 1);
        brn(1, 3, 1, 1, 0);

        // PC wrap from 0x3FF
        lutw(0, 'h3FF);
        brn(0, 0, 0, 0, 0);
        idle(2);

        // Halt, ignored inputs, then re-run
        run_to(7);
        step(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 2, 1, 1, 1, 0, 0, 0);
        step(0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(3);

        // Write-during-read: branch sees the old LUT entry
        lutw(3, 'h020);
        step(0, 1, 0, 0, 3, 0, 0, 0, 1, 3, 'h100);
        idle(2);
        brn(0, 0, 3, 0, 0);
        idle(1);

        // Counter run: abort, relaunch, 10 run cycles with 3 taken branches, halt
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(1);
        for (int i = 0; i < 10; i++) begin
            if (i == 1 || i == 4 || i == 8) brn(0, 0, 2, 0, 0);
            else idle(1);
        end
        step(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        idle(3);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Random traffic with one asynchronous reset in the middle
        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                #2 Reset_n = 1'b0;
                #1 chk_reset_outputs("async_reset");
                step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
                Reset_n = 1'b1;
            end
            step($urandom_range(0, 24) == 0, $urandom_range(0, 2) == 0, 1'($urandom),
                 $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 19) == 0,
                 1'($urandom), 1'($urandom), $urandom_range(0, 3) == 0,
                 $urandom_range(0, 3), $urandom_range(0, 1023));
        end

        for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge Clk);
        chk("scoreboard_drain", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
